// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and EX forwarding selects.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_STALL = 2'd1,
    MD_BUSY  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam int DEF_REG_W  = 5;
  localparam int DEF_MD_LAT = 4;
  localparam int DEF_CNT_W  = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-register view seen by the hazard controller (master = pipeline, slave = controller).
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] RsD, RtD, RsE, RtE;
  logic [REG_W-1:0] writeRegE, writeRegM, writeRegW;
  logic             regWriteE, regWriteM, regWriteW;
  logic             memToRegE, branchD, branchTakenD, mdStartE;
  logic             stallF, stallD, flushD, flushE;
  logic [1:0]       forwardAE, forwardBE;
  logic             forwardAD, forwardBD, mdBusy;

  modport master (
    output RsD, RtD, RsE, RtE, writeRegE, writeRegM, writeRegW,
           regWriteE, regWriteM, regWriteW, memToRegE, branchD, branchTakenD, mdStartE,
    input  stallF, stallD, flushD, flushE, forwardAE, forwardBE, forwardAD, forwardBD, mdBusy
  );

  modport slave (
    input  RsD, RtD, RsE, RtE, writeRegE, writeRegM, writeRegW,
           regWriteE, regWriteM, regWriteW, memToRegE, branchD, branchTakenD, mdStartE,
    output stallF, stallD, flushD, flushE, forwardAE, forwardBE, forwardAD, forwardBD, mdBusy
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// EX operand forwarding select for one source register; M result beats W result.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] dst_m,
  input  logic [REG_W-1:0] dst_w,
  input  logic             rw_m,
  input  logic             rw_w,
  output fwd_sel_t         sel
);

  always_comb begin
    sel = FWD_RF;
    if (rw_m && dst_m != '0 && dst_m == src)
      sel = FWD_MEM;
    else if (rw_w && dst_w != '0 && dst_w == src)
      sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: load-use / branch / multi-cycle stalls, taken-branch flush, operand forwarding.
// Build option HAZARD_FWD_EN: when undefined, no forwarding and RAW hazards on D stall until W retires.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W  = DEF_REG_W,
  parameter int MD_LAT = DEF_MD_LAT,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  hz
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ld_use, br_haz, raw_haz, stall, md_busy;
  fwd_sel_t         sel_a, sel_b;
  logic             fwd_ad, fwd_bd;

  function automatic logic hit(input logic rw, input logic [REG_W-1:0] dst,
                               input logic [REG_W-1:0] src);
    return rw && (dst != '0) && (dst == src);
  endfunction

  assign ld_use = hz.memToRegE &&
                  (hit(hz.regWriteE, hz.writeRegE, hz.RsD) || hit(hz.regWriteE, hz.writeRegE, hz.RtD));

  // No memToRegM port: a load sitting in M is exactly the LD_STALL cycle.
  assign br_haz = hz.branchD &&
                  (hit(hz.regWriteE, hz.writeRegE, hz.RsD) || hit(hz.regWriteE, hz.writeRegE, hz.RtD) ||
                   ((state == LD_STALL) &&
                    (hit(hz.regWriteM, hz.writeRegM, hz.RsD) || hit(hz.regWriteM, hz.writeRegM, hz.RtD))));

`ifdef HAZARD_FWD_EN
  hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
    .src(hz.RsE), .dst_m(hz.writeRegM), .dst_w(hz.writeRegW),
    .rw_m(hz.regWriteM), .rw_w(hz.regWriteW), .sel(sel_a)
  );
  hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
    .src(hz.RtE), .dst_m(hz.writeRegM), .dst_w(hz.writeRegW),
    .rw_m(hz.regWriteM), .rw_w(hz.regWriteW), .sel(sel_b)
  );
  assign fwd_ad  = hit(hz.regWriteM, hz.writeRegM, hz.RsD);
  assign fwd_bd  = hit(hz.regWriteM, hz.writeRegM, hz.RtD);
  assign raw_haz = 1'b0;
`else
  logic unused_ex;
  assign unused_ex = ^{hz.RsE, hz.RtE};
  assign sel_a     = FWD_RF;
  assign sel_b     = FWD_RF;
  assign fwd_ad    = 1'b0;
  assign fwd_bd    = 1'b0;
  // Without bypass paths, any in-flight producer of a D source holds D until it leaves W.
  assign raw_haz = hit(hz.regWriteE, hz.writeRegE, hz.RsD) || hit(hz.regWriteE, hz.writeRegE, hz.RtD) ||
                   hit(hz.regWriteM, hz.writeRegM, hz.RsD) || hit(hz.regWriteM, hz.writeRegM, hz.RtD) ||
                   hit(hz.regWriteW, hz.writeRegW, hz.RsD) || hit(hz.regWriteW, hz.writeRegW, hz.RtD);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    md_busy = 1'b0;
    case (state)
      IDLE: begin
        stall = ld_use || br_haz || raw_haz;
        if (hz.mdStartE) begin
          state_n = MD_BUSY;
          cnt_n   = CNT_W'(MD_LAT - 1);
        end else if (ld_use) begin
          state_n = LD_STALL;
        end
      end
      LD_STALL: begin
        stall   = ld_use || br_haz || raw_haz;
        state_n = ld_use ? LD_STALL : IDLE;
      end
      MD_BUSY: begin
        stall   = 1'b1;
        md_busy = 1'b1;
        cnt_n   = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Reset forces a bubble into ID->EX and masks everything else, independent of the clock.
  always_comb begin
    hz.stallF    = rst_n && stall;
    hz.stallD    = rst_n && stall;
    hz.flushE    = !rst_n || stall;
    hz.flushD    = rst_n && hz.branchTakenD && !stall;
    hz.mdBusy    = rst_n && md_busy;
    hz.forwardAE = rst_n ? sel_a : FWD_RF;
    hz.forwardBE = rst_n ? sel_b : FWD_RF;
    hz.forwardAD = rst_n && fwd_ad;
    hz.forwardBD = rst_n && fwd_bd;
  end

endmodule
